dec3_8_seq: RTL and testbench
=============================

// Module: dec3_8_seq
// PURPOSE
//  Sequenced 3-to-8 decoder, the receive-side counterpart of the 8:3 encoder.
//  Accepts 3-bit codes over a valid/ready handshake and buffers them in a small FIFO.
//  Replays each code as a registered one-hot strobe on y[7:0], held for HOLD_CYCLES,
//  then blanked for GAP_CYCLES. Drives one-hot select/enable lines downstream of an encoder link.
// PARAMETERS
//  DEPTH        2  FIFO entries; power of 2, >=2
//  HOLD_CYCLES  4  cycles each one-hot output is held; >=1
//  GAP_CYCLES   1  idle cycles with y=0 between codes; >=0
// PORTS
//  clk       in   1  single clock, all state updates on posedge
//  rst_n     in   1  synchronous, active-low reset
//  en        in   1  1 = FSM may pop new codes; 0 = finish current code, then stall
//  in_code   in   3  binary code, 0..7
//  in_valid  in   1  in_code valid this cycle
//  in_ready  out  1  = !fifo_full (combinational from FIFO state)
//  y         out  8  registered one-hot output; 8'b0 when not holding
//  y_valid   out  1  registered; 1 while y holds a decoded code
//  busy      out  1  = (state != IDLE) || !fifo_empty
// BEHAVIOUR
//  Reset (rst_n==0 at posedge)
//   - FIFO flushed; state=IDLE; counters=0; y=8'b0; y_valid=0.
//   - in_ready=1 and busy=0 from the following cycle.
//   - Applies mid-HOLD/GAP: outputs zero after that edge, buffered codes discarded.
//  Input handshake
//   - Push on posedge when in_valid && in_ready.
//   - in_ready = !full only: a pop in the same cycle does not free a slot for that push.
//   - in_code is stored unmodified (all 8 values legal).
//  FSM: IDLE, HOLD, GAP
//   - IDLE: if en && !empty -> pop, y <= 8'b1 << code, y_valid <= 1, hold_cnt <= HOLD_CYCLES-1, -> HOLD.
//   - HOLD, hold_cnt != 0: decrement.
//   - HOLD, hold_cnt == 0 and GAP_CYCLES==0: if en && !empty, load next code (back-to-back strobes);
//     otherwise y <= 0, y_valid <= 0, -> IDLE.
//   - HOLD, hold_cnt == 0 and GAP_CYCLES>0: y <= 0, y_valid <= 0, gap_cnt <= GAP_CYCLES-1, -> GAP.
//   - GAP: count down; at 0, if en && !empty load next code (-> HOLD), else -> IDLE.
//  Latency: code pushed at edge N into an empty FIFO, state IDLE, en=1 -> y valid after edge N+1.
//  Hold: y_valid is high for exactly HOLD_CYCLES cycles per code.
//  Spacing: consecutive codes are separated by exactly GAP_CYCLES cycles of y==0.
//  en deassertion
//   - Never truncates a HOLD or GAP in progress.
//   - Only blocks the next pop; the FIFO keeps accepting while not full.
//  Invariants: y is $onehot0 at all times; y_valid == |y; codes leave in FIFO order (no drop, no dup).
//  Widths: hold_cnt is $clog2(HOLD_CYCLES+1) bits; gap_cnt is $clog2(GAP_CYCLES+1) bits (min 1);
//   FIFO pointers carry an extra wrap bit for full/empty.
// STRUCTURE
//  Shared package dec_pkg: CODE_W=3, OUT_W=8, typedef enum {IDLE,HOLD,GAP} dec_state_t.
//  Sub-module code_fifo: synchronous FIFO, params WIDTH=CODE_W and DEPTH.
//   - Same clk/rst_n; push/pop/full/empty; pointer wrap via extra MSB.
//  Top level: FSM, two down-counters, registered decode (1 << code).
// TESTING
//  1 Reset: hold rst_n=0 3 cycles -> y=0, y_valid=0, in_ready=1, busy=0; release -> outputs unchanged.
//  2 Single code, defaults: push 3'd5 at edge N
//     -> y=8'b0010_0000 for cycles N+1..N+4; y=0 at N+5 (gap); busy=0 by N+6.
//  3 Burst: codes 0..7 pushed back-to-back with en=1
//     -> in_ready drops when 2 entries are buffered;
//     -> y steps 01,02,04,...,80, each held 4 cycles with 1 zero cycle between; no loss, no reorder.
//  4 GAP_CYCLES=0, HOLD_CYCLES=1: stream 3'd1,3'd2 -> y=02 then 04 on consecutive cycles, y never 0 between.
//  5 en=0 with 2 codes buffered: no y activity and busy=1;
//     raise en -> decode resumes next edge; dropping en mid-HOLD still completes that hold.
//  6 Reset mid-HOLD with full FIFO -> y=0 next cycle, FIFO empty, no stale code emitted after release.

Source files
------------

// File: rtl/dec_pkg.sv
// dec_pkg: shared widths, FSM states and decode helper for the sequenced 3-to-8 decoder
package dec_pkg;
   localparam int CODE_W = 3;
   localparam int OUT_W = 8;
   typedef enum logic [1:0] {IDLE, HOLD, GAP} dec_state_t;
   function automatic logic [OUT_W-1:0] decode(input logic [CODE_W-1:0] code);
      return OUT_W'(1) << code;
   endfunction
endpackage

// File: rtl/dec3_8_seq_if.sv
// dec3_8_seq_if: code input handshake and one-hot strobe output of the sequenced decoder
interface dec3_8_seq_if;
   import dec_pkg::*;
   logic [CODE_W-1:0] in_code;
   logic in_valid;
   logic in_ready;
   logic [OUT_W-1:0] y;
   logic y_valid;
   modport master (output in_code, in_valid, input in_ready, y, y_valid);
   modport slave (input in_code, in_valid, output in_ready, y, y_valid);
endinterface

// File: rtl/code_fifo.sv
// code_fifo: synchronous FIFO with wrap-bit pointers; push/pop are ignored when full/empty
module code_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic wr_en, rd_en;
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   assign empty = wr_ptr == rd_ptr;
   assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_data = mem[rd_ptr[AW-1:0]];
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
   end
endmodule

// File: rtl/dec3_8_seq.sv
// dec3_8_seq: buffers 3-bit codes and replays each as a one-hot strobe held HOLD_CYCLES,
// separated by GAP_CYCLES of y==0
module dec3_8_seq
   import dec_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   dec3_8_seq_if.slave bus,
   output logic busy
);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);
   localparam logic [GW-1:0] GAP_INIT = GW'(GAP_CYCLES - 1);
   dec_state_t state, state_d;
   logic [HW-1:0] hold_cnt, hold_d;
   logic [GW-1:0] gap_cnt, gap_d;
   logic [OUT_W-1:0] y_q, y_d;
   logic y_valid_q;
   logic [CODE_W-1:0] rd_data;
   logic full, empty, pop, load, start;
   code_fifo #(.WIDTH(CODE_W), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (bus.in_valid && bus.in_ready),
      .pop    (pop),
      .wr_data(bus.in_code),
      .rd_data(rd_data),
      .full   (full),
      .empty  (empty)
   );
   assign bus.in_ready = !full;
   assign bus.y = y_q;
   assign bus.y_valid = y_valid_q;
   assign busy = (state != IDLE) || !empty;
   assign load = en && !empty;
   // start overrides whatever the state branch decided, so a load always wins
   always_comb begin
      state_d = state;
      hold_d = hold_cnt;
      gap_d = gap_cnt;
      y_d = y_q;
      start = 1'b0;
      pop = 1'b0;
      case (state)
         IDLE: start = load;
         HOLD: begin
            if (hold_cnt != '0) hold_d = hold_cnt - 1'b1;
            else begin
               y_d = '0;
               gap_d = GAP_INIT;
               state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
               start = (GAP_CYCLES == 0) && load;
            end
         end
         GAP: begin
            if (gap_cnt != '0) gap_d = gap_cnt - 1'b1;
            else begin
               state_d = IDLE;
               start = load;
            end
         end
         default: state_d = IDLE;
      endcase
      if (start) begin
         pop = 1'b1;
         y_d = decode(rd_data);
         hold_d = HOLD_INIT;
         state_d = HOLD;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         hold_cnt <= '0;
         gap_cnt <= '0;
         y_q <= '0;
         y_valid_q <= 1'b0;
      end else begin
         state <= state_d;
         hold_cnt <= hold_d;
         gap_cnt <= gap_d;
         y_q <= y_d;
         y_valid_q <= |y_d;
      end
   end
endmodule

// File: tb/tb_dec3_8_seq.sv
// tb_dec3_8_seq: scoreboard bench; pushes queue expected strobes, a monitor pops them as strobes start
module tb_dec3_8_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic en_b = 1'b1;
   logic busy, busy_b;
   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q [$];
   logic [7:0] cur = '0;
   int run = 0;
   int zeros = 0;
   bit seen = 0;
   bit spacing_chk = 0;
   bit stalled = 0;
   logic [7:0] burst_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
   dec3_8_seq_if a_if ();
   dec3_8_seq_if b_if ();
   dec3_8_seq dut (.clk(clk), .rst_n(rst_n), .en(en), .bus(a_if.slave), .busy(busy));
   dec3_8_seq #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en_b), .bus(b_if.slave), .busy(busy_b)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic push(input logic [2:0] c, input logic [7:0] exp, input bit record);
      int t;
      t = 0;
      a_if.in_code = c;
      a_if.in_valid = 1'b1;
      while (!a_if.in_ready && t < 200) begin
         stalled = 1;
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: code %0d never accepted", c);
      end else begin
         if (record) exp_q.push_back(exp);
         @(posedge clk);
      end
      @(negedge clk);
      a_if.in_valid = 1'b0;
   endtask
   task automatic wait_idle();
      int t;
      t = 0;
      while (busy && t < 500) begin
         @(negedge clk);
         t++;
      end
      repeat (2) @(negedge clk);
      chk("idle_reached", 32'(t < 500), 1);
      chk("drain", exp_q.size(), 0);
   endtask
   // monitor: samples 1 time unit after each edge
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         run = 0;
         zeros = 0;
      end else begin
         chk("onehot0", 32'($onehot0(a_if.y)), 1);
         chk("yvalid_eq_or", 32'(a_if.y_valid), 32'(|a_if.y));
         if (a_if.y_valid) begin
            if (run == 0) begin
               if (spacing_chk && seen) chk("gap_len", zeros, 1);
               seen = 1;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_strobe: got %0h expected none", a_if.y);
               end else begin
                  cur = exp_q.pop_front();
                  chk("strobe", a_if.y, cur);
               end
            end else chk("strobe_hold", a_if.y, cur);
            run++;
            if (run == 4) run = 0;
            zeros = 0;
         end else begin
            if (run != 0) begin
               checks++;
               errors++;
               $display("FAIL truncated_hold: got %0d cycles expected 4", run);
            end
            run = 0;
            zeros++;
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      a_if.in_valid = 1'b0;
      a_if.in_code = '0;
      b_if.in_valid = 1'b0;
      b_if.in_code = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_y", a_if.y, 0);
      chk("rst_yv", a_if.y_valid, 0);
      chk("rst_ready", a_if.in_ready, 1);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_y", a_if.y, 0);
      chk("rel_ready", a_if.in_ready, 1);
      chk("rel_busy", busy, 0);
      // single code with default timing
      en = 1'b1;
      push(3'd5, 8'h20, 1);
      chk("lat_early", a_if.y, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("single_hold", a_if.y, 8'h20);
      end
      @(negedge clk);
      chk("single_gap", a_if.y, 0);
      @(negedge clk);
      chk("single_busy", busy, 0);
      // burst of all eight codes
      repeat (3) @(negedge clk);
      seen = 0;
      spacing_chk = 1;
      stalled = 0;
      for (int i = 0; i < 8; i++) push(3'(i), burst_exp[i], 1);
      chk("burst_stalled", 32'(stalled), 1);
      wait_idle();
      spacing_chk = 0;
      // en low with two codes buffered
      en = 1'b0;
      push(3'd3, 8'h08, 1);
      push(3'd6, 8'h40, 1);
      repeat (4) @(negedge clk);
      chk("en0_yv", a_if.y_valid, 0);
      chk("en0_busy", busy, 1);
      chk("en0_full", a_if.in_ready, 0);
      en = 1'b1;
      @(negedge clk);
      chk("resume", a_if.y, 8'h08);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("en_drop_hold", a_if.y, 8'h08);
      end
      @(negedge clk);
      chk("en_drop_end", a_if.y, 0);
      repeat (4) @(negedge clk);
      chk("en0_stall_yv", a_if.y_valid, 0);
      chk("en0_stall_busy", busy, 1);
      en = 1'b1;
      wait_idle();
      // back-to-back strobes on the no-gap instance
      b_if.in_code = 3'd1;
      b_if.in_valid = 1'b1;
      @(negedge clk);
      b_if.in_code = 3'd2;
      @(negedge clk);
      b_if.in_valid = 1'b0;
      chk("b2b_first", b_if.y, 8'h02);
      chk("b2b_first_v", b_if.y_valid, 1);
      @(negedge clk);
      chk("b2b_second", b_if.y, 8'h04);
      @(negedge clk);
      chk("b2b_end", b_if.y, 0);
      chk("b2b_busy", busy_b, 0);
      // reset mid-hold with a full FIFO
      push(3'd1, 8'h02, 1);
      push(3'd2, 8'h04, 0);
      push(3'd4, 8'h10, 0);
      chk("pre_rst_y", a_if.y, 8'h02);
      chk("pre_rst_full", a_if.in_ready, 0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_y", a_if.y, 0);
      chk("midrst_yv", a_if.y_valid, 0);
      @(negedge clk);
      chk("midrst_ready", a_if.in_ready, 1);
      chk("midrst_busy", busy, 0);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("post_rst_yv", a_if.y_valid, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_q", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
